seq1101_frame_tx: RTL and testbench

Framed serial transmitter that drives the 1101-sequence detector's serial input. It accepts 16-bit words over a valid/ready handshake and double-buffers them. Each word goes out MSB-first, aligned to a free-running 16-cycle frame timer. A built-in 1101 tracker produces the expected per-frame hit mask and count, so a bench or on-chip checker can compare them against the detector's latched results.

---
 rtl/seq1101_pkg.sv | 24 ++
 rtl/seq1101_frame_tx_if.sv | 11 +
 rtl/seq1101_tracker.sv | 44 ++++
 rtl/seq1101_frame_tx.sv | 156 +++++++++++++++
 tb/tb_seq1101_frame_tx.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/seq1101_pkg.sv
// Shared types and constants for the framed 1101 transmitter and its tracker.
// The period-3 mask is where hits land when a frame carries back-to-back overlapping 1101s.
package seq1101_pkg;

  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = 3;

  // Overlapping 1101 hits repeat every three bits, first landing on frame bit 3.
  localparam int          HIT_PERIOD       = 3;
  localparam logic [15:0] PERIOD3_HIT_MASK = 16'h9248;

  typedef enum logic [2:0] {
    NOTHING = 3'd0,
    S1      = 3'd1,
    S11     = 3'd2,
    S110    = 3'd3,
    S1101   = 3'd4
  } state_t;

  function automatic logic [FRAME_LEN-1:0] bit_onehot(input logic [3:0] k);
    bit_onehot = {{(FRAME_LEN-1){1'b0}}, 1'b1} << k;
  endfunction

endpackage

// File: rtl/seq1101_frame_tx_if.sv
// Word handshake between a producer and the framed serial transmitter.
interface seq1101_frame_tx_if;

  logic [15:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);

endinterface

// File: rtl/seq1101_tracker.sv
// Overlapping 1101 tracker; hit is asserted combinationally on the bit that completes the pattern.
module seq1101_tracker
  import seq1101_pkg::*;
(
  input  logic   clk,
  input  logic   rst,
  input  logic   clear,
  input  logic   bit_valid,
  input  logic   bit_in,
  output logic   hit,
  output state_t state
);

  state_t state_r;
  state_t state_next_s;

  // Next-state decode for one serial bit.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      NOTHING: state_next_s = bit_in ? S1    : NOTHING;
      S1:      state_next_s = bit_in ? S11   : NOTHING;
      S11:     state_next_s = bit_in ? S11   : S110;
      S110:    state_next_s = bit_in ? S1101 : NOTHING;
      S1101:   state_next_s = bit_in ? S11   : NOTHING;
      default: state_next_s = NOTHING;
    endcase
  end

  // State register; clear wins so each frame starts from NOTHING.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= NOTHING;
    end else if (clear) begin
      state_r <= NOTHING;
    end else if (bit_valid) begin
      state_r <= state_next_s;
    end
  end

  assign hit   = bit_valid && bit_in && (state_r == S110);
  assign state = state_r;

endmodule

// File: rtl/seq1101_frame_tx.sv
// Framed MSB-first serial transmitter with a double-buffered word input and
// a built-in 1101 tracker that reports the expected per-frame hit mask and count.
module seq1101_frame_tx #(
  parameter int FRAME_LEN = 16,
  parameter int CNT_W     = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  seq1101_frame_tx_if.slave    tx,
  output logic                 sout,
  output logic                 frame_sync,
  output logic                 frame_active,
  output logic [FRAME_LEN-1:0] exp_mask,
  output logic [CNT_W-1:0]     exp_count,
  output logic                 exp_valid,
  output logic                 underrun
);

  localparam int            TW       = $clog2(FRAME_LEN);
  localparam logic [TW-1:0] LAST_BIT = TW'(FRAME_LEN - 1);

  logic [TW-1:0]        timer_r;
  logic [FRAME_LEN-1:0] hold_r;
  logic                 hold_valid_r;
  logic [FRAME_LEN-1:0] shift_r;
  logic                 frame_active_r;
  logic                 frame_sync_r;
  logic [FRAME_LEN-1:0] acc_mask_r;
  logic [CNT_W-1:0]     acc_count_r;
  logic [FRAME_LEN-1:0] exp_mask_r;
  logic [CNT_W-1:0]     exp_count_r;
  logic                 exp_valid_r;
  logic                 underrun_r;

  logic                 frame_end_s;
  logic                 tx_ready_s;
  logic                 accept_s;
  logic                 load_any_s;
  logic [FRAME_LEN-1:0] load_word_s;
  logic                 hit_s;
  seq1101_pkg::state_t  trk_state_s;
  logic [FRAME_LEN-1:0] mask_next_s;
  logic [CNT_W-1:0]     count_next_s;

  assign frame_end_s = (timer_r == LAST_BIT);
  assign tx_ready_s  = !hold_valid_r || frame_end_s;
  assign accept_s    = tx.tx_valid && tx_ready_s;
  // An empty hold at the boundary lets a word arriving on that edge start immediately.
  assign load_any_s  = hold_valid_r || accept_s;
  assign load_word_s = hold_valid_r ? hold_r : tx.tx_data;
  assign tx.tx_ready = tx_ready_s;

  seq1101_tracker u_tracker (
    .clk       (clk),
    .rst       (rst),
    .clear     (frame_end_s),
    .bit_valid (frame_active_r),
    .bit_in    (shift_r[FRAME_LEN-1]),
    .hit       (hit_s),
    .state     (trk_state_s)
  );

  // Accumulator update for the bit currently on sout; hits are honoured only from S110.
  always_comb begin
    mask_next_s  = acc_mask_r;
    count_next_s = acc_count_r;
    if (hit_s && (trk_state_s == seq1101_pkg::S110)) begin
      mask_next_s  = acc_mask_r | seq1101_pkg::bit_onehot(timer_r);
      count_next_s = acc_count_r + CNT_W'(1'b1);
    end else begin
      mask_next_s  = acc_mask_r;
      count_next_s = acc_count_r;
    end
  end

  // Free-running frame timer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      timer_r <= '0;
    end else begin
      timer_r <= timer_r + TW'(1'b1);
    end
  end

  // Hold buffer; a word taken while the frame is being loaded from hold waits for the next frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_r       <= '0;
      hold_valid_r <= 1'b0;
    end else if (accept_s && (hold_valid_r || !frame_end_s)) begin
      hold_r       <= tx.tx_data;
      hold_valid_r <= 1'b1;
    end else if (frame_end_s) begin
      hold_valid_r <= 1'b0;
    end
  end

  // Shift register and frame flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_r        <= '0;
      frame_active_r <= 1'b0;
      frame_sync_r   <= 1'b0;
    end else if (frame_end_s) begin
      if (load_any_s) begin
        shift_r        <= load_word_s;
        frame_active_r <= 1'b1;
        frame_sync_r   <= 1'b1;
      end else begin
        shift_r        <= '0;
        frame_active_r <= 1'b0;
        frame_sync_r   <= 1'b0;
      end
    end else begin
      shift_r      <= {shift_r[FRAME_LEN-2:0], 1'b0};
      frame_sync_r <= 1'b0;
    end
  end

  // Per-frame accumulators and the latched expectation outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_mask_r  <= '0;
      acc_count_r <= '0;
      exp_mask_r  <= '0;
      exp_count_r <= '0;
      exp_valid_r <= 1'b0;
      underrun_r  <= 1'b0;
    end else if (frame_end_s) begin
      exp_valid_r <= frame_active_r;
      underrun_r  <= frame_active_r && !load_any_s;
      if (frame_active_r) begin
        exp_mask_r  <= mask_next_s;
        exp_count_r <= count_next_s;
      end
      acc_mask_r  <= '0;
      acc_count_r <= '0;
    end else begin
      exp_valid_r <= 1'b0;
      underrun_r  <= 1'b0;
      if (frame_active_r) begin
        acc_mask_r  <= mask_next_s;
        acc_count_r <= count_next_s;
      end
    end
  end

  assign sout         = shift_r[FRAME_LEN-1];
  assign frame_sync   = frame_sync_r;
  assign frame_active = frame_active_r;
  assign exp_mask     = exp_mask_r;
  assign exp_count    = exp_count_r;
  assign exp_valid    = exp_valid_r;
  assign underrun     = underrun_r;

endmodule

// File: tb/tb_seq1101_frame_tx.sv
// Self-checking bench: directed scenarios plus random traffic against a frame-level reference model.
module tb_seq1101_frame_tx;

  int total = 0;
  int bad   = 0;

  logic        clk = 1'b0;
  logic        rst;
  logic        sout;
  logic        frame_sync;
  logic        frame_active;
  logic [15:0] exp_mask;
  logic [2:0]  exp_count;
  logic        exp_valid;
  logic        underrun;

  always #5 clk = ~clk;

  seq1101_frame_tx_if bus ();

  seq1101_frame_tx #(.FRAME_LEN(16), .CNT_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .tx           (bus.slave),
    .sout         (sout),
    .frame_sync   (frame_sync),
    .frame_active (frame_active),
    .exp_mask     (exp_mask),
    .exp_count    (exp_count),
    .exp_valid    (exp_valid),
    .underrun     (underrun)
  );

  // Reference model: cycle position, words waiting, word on the line, latched results.
  int          t;
  logic [15:0] q[$];
  logic [15:0] cur_word;
  bit          cur_active;
  logic [15:0] m_mask;
  int          m_count;
  bit          m_ev;
  bit          m_ur;
  int          ev_seen   = 0;
  int          ur_seen   = 0;
  int          sync_seen = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h (time %0t)", tag, got, exp, $time);
    end
  endtask

  // Hit at frame bit k when bits k-3..k (in sending order) read 1,1,0,1.
  function automatic logic [15:0] ref_mask(input logic [15:0] w);
    logic [15:0] m;
    logic [15:0] b;
    m = 16'h0000;
    for (int k = 0; k < 16; k++) b[k] = w[15-k];
    for (int k = 3; k < 16; k++) begin
      if (b[k-3] && b[k-2] && !b[k-1] && b[k]) m[k] = 1'b1;
    end
    return m;
  endfunction

  function automatic int popc(input logic [15:0] m);
    int n;
    n = 0;
    for (int k = 0; k < 16; k++) n += int'(m[k]);
    return n;
  endfunction

  task automatic model_reset();
    t          = 0;
    q.delete();
    cur_word   = 16'h0000;
    cur_active = 1'b0;
    m_mask     = 16'h0000;
    m_count    = 0;
    m_ev       = 1'b0;
    m_ur       = 1'b0;
  endtask

  task automatic model_step(input bit acc, input logic [15:0] d);
    bit ending;
    if (acc) q.push_back(d);
    if (t == 15) begin
      ending = cur_active;
      if (ending) begin
        m_mask  = ref_mask(cur_word);
        m_count = popc(m_mask);
      end
      m_ev = ending;
      if (q.size() != 0) begin
        cur_word   = q.pop_front();
        cur_active = 1'b1;
      end else begin
        cur_word   = 16'h0000;
        cur_active = 1'b0;
      end
      m_ur = ending && !cur_active;
    end else begin
      m_ev = 1'b0;
      m_ur = 1'b0;
    end
    t = (t + 1) % 16;
  endtask

  // One clock cycle: starts and ends at a falling edge.
  task automatic run_cycle(input bit v, input logic [15:0] d, output bit acc);
    bit exp_ready;
    bit exp_sout;
    bus.tx_valid = v;
    bus.tx_data  = d;
    exp_ready = (q.size() == 0) || (t == 15);
    exp_sout  = cur_active ? cur_word[15-t] : 1'b0;
    #1;
    check_eq("sout", sout, exp_sout);
    check_eq("frame_active", frame_active, cur_active);
    check_eq("frame_sync", frame_sync, cur_active && (t == 0));
    check_eq("exp_valid", exp_valid, m_ev);
    check_eq("underrun", underrun, m_ur);
    check_eq("exp_mask", exp_mask, m_mask);
    check_eq("exp_count", exp_count, m_count);
    check_eq("tx_ready", bus.tx_ready, exp_ready);
    if (exp_valid === 1'b1) ev_seen++;
    if (underrun === 1'b1) ur_seen++;
    if (frame_sync === 1'b1) sync_seen++;
    acc = v && exp_ready;
    @(posedge clk);
    model_step(acc, d);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit acc;
    logic [15:0] r;
    for (int i = 0; i < n; i++) begin
      r = 16'($urandom);
      run_cycle(1'b0, r, acc);
    end
  endtask

  task automatic send_word(input logic [15:0] d);
    bit acc;
    acc = 1'b0;
    for (int i = 0; i < 40 && !acc; i++) run_cycle(1'b1, d, acc);
    check_eq("accept_timeout", acc, 1'b1);
  endtask

  // Assert reset at a falling edge; outputs must clear at once.
  task automatic do_reset();
    bus.tx_valid = 1'b0;
    rst = 1'b1;
    #1;
    check_eq("rst_sout", sout, 1'b0);
    check_eq("rst_frame_active", frame_active, 1'b0);
    check_eq("rst_frame_sync", frame_sync, 1'b0);
    check_eq("rst_exp_valid", exp_valid, 1'b0);
    check_eq("rst_underrun", underrun, 1'b0);
    check_eq("rst_exp_mask", exp_mask, 16'h0000);
    check_eq("rst_exp_count", exp_count, 3'd0);
    check_eq("rst_tx_ready", bus.tx_ready, 1'b1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int ev0;
    int ur0;
    int sy0;
    bit acc;
    bit v;
    logic [15:0] d;
    logic [15:0] r;

    rst          = 1'b1;
    bus.tx_valid = 1'b0;
    bus.tx_data  = 16'h0000;
    model_reset();
    @(negedge clk);
    do_reset();

    // Single 0xD000 frame followed by silence: one result, one underrun.
    ev0 = ev_seen; ur0 = ur_seen; sy0 = sync_seen;
    send_word(16'hD000);
    idle(40);
    check_eq("d000_mask", exp_mask, 16'h0008);
    check_eq("d000_count", exp_count, 3'd1);
    check_eq("d000_ev_pulses", ev_seen - ev0, 1);
    check_eq("d000_underruns", ur_seen - ur0, 1);
    check_eq("d000_syncs", sync_seen - sy0, 1);

    // Maximum overlap: five hits at period 3.
    send_word(16'hDB6D);
    idle(40);
    check_eq("db6d_mask", exp_mask, 16'h9248);
    check_eq("db6d_count", exp_count, 3'd5);

    // Back-to-back frames with tx_valid held high.
    ev0 = ev_seen; ur0 = ur_seen; sy0 = sync_seen;
    send_word(16'hFFFF);
    send_word(16'h0000);
    idle(40);
    check_eq("b2b_count", exp_count, 3'd0);
    check_eq("b2b_mask", exp_mask, 16'h0000);
    check_eq("b2b_ev_pulses", ev_seen - ev0, 2);
    check_eq("b2b_syncs", sync_seen - sy0, 2);
    check_eq("b2b_underruns", ur_seen - ur0, 1);

    // Hold full while tx_valid stays high across the boundary.
    ev0 = ev_seen;
    send_word(16'hD00D);
    send_word(16'h1B60);
    send_word(16'hDDDD);
    idle(60);
    check_eq("hold_full_ev_pulses", ev_seen - ev0, 3);
    check_eq("hold_full_last_mask", exp_mask, {16'h0000 | ref_mask(16'hDDDD)});

    // Random traffic.
    for (int i = 0; i < 800; i++) begin
      r = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       d = 16'hDB6D;
        1:       d = 16'hD000 ^ {4'h0, r[11:0]};
        2:       d = r;
        default: d = {r[15:8], 8'h6D};
      endcase
      v = ($urandom_range(0, 9) < 7);
      run_cycle(v, d, acc);
    end
    idle(40);

    // Reset in the middle of a frame: no result for it.
    send_word(16'hD000);
    for (int i = 0; i < 40 && !(cur_active && t == 7); i++) idle(1);
    check_eq("reach_bit7", (cur_active && t == 7), 1'b1);
    check_eq("mid_frame_active", frame_active, 1'b1);
    ev0 = ev_seen; ur0 = ur_seen;
    do_reset();
    idle(40);
    check_eq("rst_mid_no_ev", ev_seen - ev0, 0);
    check_eq("rst_mid_no_underrun", ur_seen - ur0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
